myproject_mac_accum_requant: RTL and testbench
==============================================

Name: myproject_mac_accum_requant

Overview:
- Downstream consumer of the 19x17 unsigned multiplier stage; takes its 36-bit unsigned products one per beat.
- Accumulates N_IN products plus a bias into one dense-layer output neuron.
- Requantizes the sum by right shift, with saturation, to the layer output width.
- Presents the result on a valid/ready handshake to the next layer stage.

Parameters:
- N_IN, 16, products accumulated per output (>=2)
- PROD_W, 36, product input width (unsigned)
- BIAS_W, 24, bias width (unsigned, same scale as products)
- ACC_W, 44, accumulator width; must hold N_IN*(2^PROD_W-1) + 2^BIAS_W-1 + 2^(SHIFT-1)
- SHIFT, 18, right-shift applied to final accumulator
- OUT_W, 16, output width (unsigned)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst  in  1  synchronous active-high reset
- in_data  in  PROD_W  product from multiplier stage
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- bias  in  BIAS_W  bias for current group; sampled on first accepted beat of group
- out_data  out  OUT_W  requantized result
- out_sat  out  1  result was clipped to max
- out_valid  out  1  out_data/out_sat valid
- out_ready  in  1  downstream accepts result

Behaviour:
- Reset (ap_rst=1 at clock edge): state=ACCUM, count=0, acc=0, out_valid=0, out_data=0, out_sat=0. Partial group discarded; takes priority over all other events.
- Beat accepted when in_valid && in_ready. Bubbles (in_valid=0) leave acc/count unchanged.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Beat with count=0: acc <= bias + in_data.
  - Beat with 0<count<N_IN-1: acc <= acc + in_data; count++.
  - Beat with count=N_IN-1: form final = acc + in_data combinationally; register out_data/out_sat; count<=0; go to OUT.
- State OUT:
  - in_ready=0, out_valid=1; out_data/out_sat held stable.
  - On out_ready=1, return to ACCUM next cycle with out_valid=0.
  - No new beat accepted in the handshake cycle itself (one bubble per group).
- Latency: out_valid rises the cycle after the N_IN-th beat is accepted. Throughput: one result per N_IN+1 cycles with no backpressure.
- Requant:
  - q = final >> SHIFT, logical shift.
  - If q > 2^OUT_W-1: out_data=2^OUT_W-1, out_sat=1. Else out_data=q[OUT_W-1:0], out_sat=0.
  - All arithmetic unsigned, zero-extended to ACC_W; no accumulator wrap with the stated ACC_W rule.
- out_ready ignored in ACCUM; in_valid ignored in OUT; data not consumed.

Optional Feature:
- Macro MYPROJECT_ACC_ROUND_EN.
- Defined: final term adds 2^(SHIFT-1) before shift (round half up); rounding carry can trigger saturation.
- Undefined: plain truncation. Latency and handshake identical in both builds.

Test Plan:
- Basic sum: bias=0, 16 beats in_data=2^18 back-to-back, out_ready=1 -> out_valid one cycle after 16th beat, out_data=16, out_sat=0, in_ready low exactly one cycle.
- Bias plus bubbles: bias=2^20, 16 beats of 2^18 with in_valid low every other cycle -> out_data=20; bias value changed after first beat has no effect.
- Saturation: 16 beats in_data=2^36-1, bias=2^24-1 -> out_data=65535, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable, in_ready=0 throughout; next group starts clean after handshake.
- Rounding: one beat 2^17, fifteen beats 0, bias=0 -> out_data=1 with MYPROJECT_ACC_ROUND_EN, 0 without.
- Reset mid-group: 7 beats of 2^18, assert ap_rst 1 cycle, then full group of 16x 2^18 with bias 0 -> out_data=16; all outputs 0 in cycle after reset.

Source files
------------

// File: rtl/myproject_mac_accum_requant.sv
// Purpose : accumulates N_IN unsigned products plus a bias into one neuron, then requantizes by >>SHIFT with saturation.
// Latency : out_valid rises the cycle after the N_IN-th beat is accepted; one result per N_IN+1 cycles at best.
// Backpressure: while a result waits for out_ready, in_ready is low and the result is held stable.
//
// Ports:
//   ap_clk, ap_rst        clock and synchronous active-high reset
//   in_data/valid/ready   product stream from the multiplier stage
//   bias                  group bias, sampled on the first accepted beat of each group
//   out_data/sat/valid/ready  requantized result handshake to the next layer
//
// Optional build macro: MYPROJECT_ACC_ROUND_EN adds 2^(SHIFT-1) to the final sum
// (round half up) instead of plain truncation. Timing is identical in both builds.
module myproject_mac_accum_requant #(
    parameter int N_IN   = 16,
    parameter int PROD_W = 36,
    parameter int BIAS_W = 24,
    parameter int ACC_W  = 44,
    parameter int SHIFT  = 18,
    parameter int OUT_W  = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_acc;
    logic [OUT_W-1:0]   r_out_data;
    logic               r_out_sat;

    logic [ACC_W-1:0]   w_base;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_final;
    logic [ACC_W-1:0]   w_q;
    logic               w_sat;

    // The first beat of a group starts from the bias rather than the stale accumulator,
    // so no separate clear cycle is needed between groups.
    assign w_base = (r_count == '0) ? ACC_W'(bias) : r_acc;
    assign w_sum  = w_base + ACC_W'(in_data);

`ifdef MYPROJECT_ACC_ROUND_EN
    localparam logic [ACC_W-1:0] ROUND_TERM = ACC_W'(1) << (SHIFT - 1);
    assign w_final = w_sum + ROUND_TERM;
`else
    assign w_final = w_sum;
`endif

    // Any set bit above the output width after the shift means the result does not fit.
    assign w_q   = w_final >> SHIFT;
    assign w_sat = |w_q[ACC_W-1:OUT_W];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state    <= ST_ACCUM;
            r_count    <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (r_count == LAST_CNT) begin
                            r_out_data <= w_sat ? {OUT_W{1'b1}} : w_q[OUT_W-1:0];
                            r_out_sat  <= w_sat;
                            r_count    <= '0;
                            r_state    <= ST_OUT;
                        end else begin
                            r_acc   <= w_sum;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    // The handshake cycle itself never accepts a beat: one bubble per group.
                    if (out_ready) begin
                        r_state <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_OUT);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_myproject_mac_accum_requant.sv
// Purpose : directed, table-driven check of the accumulate/requantize neuron stage.
// Latency : groups of 16 beats; result expected one cycle after the last beat.
// Backpressure: exercised by holding out_ready low with a result pending.
module tb_myproject_mac_accum_requant;

`ifdef MYPROJECT_ACC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [35:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] bias;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit rdy_bad;

    always #5 ap_clk = ~ap_clk;

    myproject_mac_accum_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        string       name;
        logic [23:0] b;
        logic [35:0] first;
        logic [35:0] rest;
        bit          bubbles;
        logic [15:0] exp_d;
        bit          exp_s;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Present one beat; inputs change 1 time unit after the edge, outputs are read there too.
    task automatic beat(input logic [35:0] d, input logic [23:0] b);
        in_valid = 1'b1;
        in_data  = d;
        bias     = b;
        if (!in_ready) rdy_bad = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // One full group of 16 beats. Bias is inverted after the first beat to show it is not re-sampled.
    task automatic run_group(input logic [23:0] b, input logic [35:0] first,
                             input logic [35:0] rest, input bit bubbles);
        rdy_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bubbles && i > 0) begin
                in_valid = 1'b0;
                in_data  = 36'hDEAD;
                @(posedge ap_clk);
                #1;
            end
            beat((i == 0) ? first : rest, (i == 0) ? b : ~b);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"basic",        24'h00_0000, 36'h0_0004_0000, 36'h0_0004_0000, 1'b0, 16'd16, 1'b0};
        vecs[1] = '{"bias_bubbles", 24'h10_0000, 36'h0_0004_0000, 36'h0_0004_0000, 1'b1, 16'd20, 1'b0};
        vecs[2] = '{"saturate",     24'hFF_FFFF, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b0, 16'hFFFF, 1'b1};
        vecs[3] = '{"round_half",   24'h00_0000, 36'h0_0002_0000, 36'h0, 1'b0, ROUND ? 16'd1 : 16'd0, 1'b0};
        vecs[4] = '{"max_nosat",    24'h00_0000, 36'h3_FFFC_0000, 36'h0, 1'b0, 16'hFFFF, 1'b0};
        vecs[5] = '{"just_over",    24'h00_0000, 36'h4_0000_0000, 36'h0, 1'b0, 16'hFFFF, 1'b1};
        vecs[6] = '{"round_carry",  24'h00_0000, 36'h3_FFFE_0000, 36'h0, 1'b0, 16'hFFFF, ROUND};
        vecs[7] = '{"mixed",        24'h0C_0000, 36'h0_0008_0000, 36'h0_0004_0000, 1'b1, 16'd20, 1'b0};
        vecs[8] = '{"fraction",     24'h00_0000, 36'h0_0007_FFFF, 36'h0, 1'b0, ROUND ? 16'd2 : 16'd1, 1'b0};

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_sat",   64'(out_sat),   64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);

        // Table: each group is followed by an immediate handshake (out_ready held high).
        for (int v = 0; v < 9; v++) begin
            run_group(vecs[v].b, vecs[v].first, vecs[v].rest, vecs[v].bubbles);
            check({vecs[v].name, "_accepted"},  64'(rdy_bad),   64'd0);
            check({vecs[v].name, "_out_valid"}, 64'(out_valid), 64'd1);
            check({vecs[v].name, "_in_ready"},  64'(in_ready),  64'd0);
            check({vecs[v].name, "_data"},      64'(out_data),  64'(vecs[v].exp_d));
            check({vecs[v].name, "_sat"},       64'(out_sat),   64'(vecs[v].exp_s));
            @(posedge ap_clk);
            #1;
            check({vecs[v].name, "_valid_drop"}, 64'(out_valid), 64'd0);
            check({vecs[v].name, "_ready_back"}, 64'(in_ready),  64'd1);
        end

        // Backpressure: result must hold while out_ready is low, even with in_valid asserted.
        out_ready = 1'b0;
        run_group(24'h0, 36'h0_0004_0000, 36'h0_0004_0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 36'hF_FFFF_FFFF;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data",  64'(out_data),  64'd16);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            @(posedge ap_clk);
            #1;
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        run_group(24'h0, 36'h0_0004_0000, 36'h0_0004_0000, 1'b0);
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_data",  64'(out_data),  64'd16);
        @(posedge ap_clk);
        #1;

        // Reset mid-group: partial accumulation must be discarded.
        for (int i = 0; i < 7; i++) beat(36'h0_0004_0000, 24'h10_0000);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_out_data",  64'(out_data),  64'd0);
        check("rst_mid_out_sat",   64'(out_sat),   64'd0);
        check("rst_mid_in_ready",  64'(in_ready),  64'd1);
        run_group(24'h0, 36'h0_0004_0000, 36'h0_0004_0000, 1'b0);
        check("rst_mid_group_valid", 64'(out_valid), 64'd1);
        check("rst_mid_group_data",  64'(out_data),  64'd16);
        check("rst_mid_group_sat",   64'(out_sat),   64'd0);
        @(posedge ap_clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
